chirp_burst_framer: RTL

Downstream stage of the chirp sample generator: it consumes the free-running 14-bit chirp stream (one sample per clk, repeating every FRAME_LEN samples, start-of-frame flagged) and turns it into triggered, counted bursts for the DAC. Between bursts it inserts a guard interval at DAC mid-scale. It also converts two's-complement samples to offset binary. It sits between the chirp ROM reader and the DAC pin drivers.

---
 rtl/chirp_burst_framer_pkg.sv | 20 ++
 rtl/chirp_burst_framer_taper.sv | 42 ++++
 rtl/chirp_burst_framer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/chirp_burst_framer_pkg.sv
// Shared types and constants for the chirp burst framer.
// Optional taper build is selected with CHIRP_FRAMER_RAMP_EN.
package chirp_burst_framer_pkg;

    localparam int unsigned DAC_W = 14;
    localparam logic [DAC_W-1:0] DAC_MIDSCALE = 14'h2000;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        BURST,
        GUARD
    } state_e;

    // Two's complement to offset binary: flipping the sign bit adds half scale.
    function automatic logic [DAC_W-1:0] to_offset_bin(input logic [DAC_W-1:0] s);
        return {~s[DAC_W-1], s[DAC_W-2:0]};
    endfunction

endpackage

// File: rtl/chirp_burst_framer_taper.sv
// chirp_taper: combinational amplitude ramp at both ends of a burst.
// Compiled only when CHIRP_FRAMER_RAMP_EN is defined.
`ifdef CHIRP_FRAMER_RAMP_EN
module chirp_taper
    import chirp_burst_framer_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 451,
    parameter int unsigned RAMP_LEN  = 16,
    parameter int unsigned CW        = 9
) (
    input  logic [DAC_W-1:0] sample_i,
    input  logic [CW-1:0]    idx_i,
    output logic [DAC_W-1:0] sample_o
);

    localparam int unsigned SH = $clog2(RAMP_LEN);
    localparam int unsigned PW = DAC_W + SH + 2;

    logic [31:0]          c;
    logic [SH:0]          weight;
    logic                 taper;
    logic signed [PW-1:0] prod;

    assign c = 32'(idx_i);

    always_comb begin
        taper  = 1'b1;
        weight = '0;
        if (c < RAMP_LEN) begin
            weight = (SH+1)'(c + 1);
        end else if (c >= FRAME_LEN - RAMP_LEN) begin
            weight = (SH+1)'(FRAME_LEN - c);
        end else begin
            taper = 1'b0;
        end
        // weight <= RAMP_LEN, so the shifted product always fits back in DAC_W bits
        prod     = PW'($signed(sample_i)) * $signed({{(PW-SH-1){1'b0}}, weight});
        sample_o = taper ? DAC_W'(prod >>> SH) : sample_i;
    end

endmodule
`endif

// File: rtl/chirp_burst_framer.sv
// Triggered, counted chirp bursts with mid-scale guard gaps and offset-binary output.
// Define CHIRP_FRAMER_RAMP_EN to add the amplitude taper (chirp_taper).
module chirp_burst_framer
    import chirp_burst_framer_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 451,
`ifdef CHIRP_FRAMER_RAMP_EN
    parameter int unsigned RAMP_LEN  = 16,
`endif
    parameter int unsigned GUARD_LEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic [7:0]       n_bursts,
    input  logic [DAC_W-1:0] chirp_in,
    input  logic             chirp_sof,
    output logic [DAC_W-1:0] dac_data,
    output logic             dac_en,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CMAX = (FRAME_LEN > GUARD_LEN) ? FRAME_LEN : GUARD_LEN;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       rem_q, rem_d;
    logic [DAC_W-1:0] dac_q, dac_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             pass;
    logic [DAC_W-1:0] shaped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dac_q   <= DAC_MIDSCALE;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dac_q   <= dac_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    // The sof cycle in ARM carries burst sample 0, so BURST resumes counting at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = ARM;
                    cnt_d   = '0;
                    rem_d   = (n_bursts == 8'd0) ? 8'd1 : n_bursts;
                end
            end
            ARM: begin
                if (chirp_sof) begin
                    state_d = BURST;
                    cnt_d   = CW'(1);
                end
            end
            BURST: begin
                if (cnt_q == CW'(FRAME_LEN - 1)) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    rem_d   = rem_q - 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GUARD: begin
                if (cnt_q == CW'(GUARD_LEN - 1)) begin
                    state_d = (rem_q != 8'd0) ? ARM : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CHIRP_FRAMER_RAMP_EN
    logic [CW-1:0] idx;
    assign idx = (state_q == BURST) ? cnt_q : '0;

    chirp_taper #(
        .FRAME_LEN(FRAME_LEN),
        .RAMP_LEN (RAMP_LEN),
        .CW       (CW)
    ) u_taper (
        .sample_i(chirp_in),
        .idx_i   (idx),
        .sample_o(shaped)
    );
`else
    assign shaped = chirp_in;
`endif

    always_comb begin
        pass   = ((state_q == ARM) && chirp_sof) || (state_q == BURST);
        en_d   = pass;
        dac_d  = pass ? to_offset_bin(shaped) : DAC_MIDSCALE;
        done_d = (state_q == GUARD) && (cnt_q == CW'(GUARD_LEN - 1)) && (rem_q == 8'd0);
    end

    assign dac_data = dac_q;
    assign dac_en   = en_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule
